// File: rtl/rvjtag_dmi_pkg.sv
// Shared types and status codes for the JTAG DMI request tracker.
package rvjtag_dmi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } dmi_state_e;

  localparam logic [1:0] DMI_OK     = 2'd0;
  localparam logic [1:0] DMI_FAILED = 2'd2;
  localparam logic [1:0] DMI_BUSY   = 2'd3;

endpackage

// File: rtl/rvjtag_dmi_timeout_ctr.sv
// Saturating response-timeout counter for the DMI tracker (used with RVJTAG_DMI_TIMEOUT_EN).
module rvjtag_dmi_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic tck_i,
  input  logic trst_ni,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CntMax);

endmodule

// File: rtl/rvjtag_dmi_tracker.sv
// Single-outstanding DMI op tracker between the JTAG TAP and the debug module.
// Optional response timeout enabled by defining RVJTAG_DMI_TIMEOUT_EN.
module rvjtag_dmi_tracker
  import rvjtag_dmi_pkg::*;
#(
  parameter int unsigned AWIDTH         = 7,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              tck_i,
  input  logic              trst_ni,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [31:0]       wr_data_i,
  input  logic              dmi_reset_i,
  input  logic              dmi_hard_reset_i,
  output logic [31:0]       rd_data_o,
  output logic [1:0]        rd_status_o,
  output logic [1:0]        dmi_stat_o,
  output logic              dmi_req_valid_o,
  input  logic              dmi_req_ready_i,
  output logic [AWIDTH-1:0] dmi_req_addr_o,
  output logic [31:0]       dmi_req_data_o,
  output logic              dmi_req_wr_o,
  input  logic              dmi_rsp_valid_i,
  input  logic [31:0]       dmi_rsp_data_i,
  input  logic              dmi_rsp_err_i
);

  dmi_state_e        state_q, state_d;
  logic [1:0]        sticky_q, sticky_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              wr_q, wr_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic [1:0]        status;
  logic              op_valid;
  logic              timeout;

  // {wr_en,rd_en} = 11 is reserved and treated as no op.
  assign op_valid = wr_en_i ^ rd_en_i;

`ifdef RVJTAG_DMI_TIMEOUT_EN
  logic expire;
  logic timer_clear;

  assign timer_clear = (state_d == WAIT) && (state_q != WAIT);
  assign timeout     = expire && (state_q == WAIT) && !dmi_rsp_valid_i;

  rvjtag_dmi_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .tck_i   (tck_i),
    .trst_ni (trst_ni),
    .clear_i (timer_clear),
    .run_i   (state_q == WAIT),
    .expire_o(expire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q   <= IDLE;
      sticky_q  <= DMI_OK;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      sticky_q  <= sticky_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sticky_d  = sticky_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = wr_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      IDLE: begin
        if (op_valid && !dmi_hard_reset_i) begin
          addr_d  = wr_addr_i;
          data_d  = wr_data_i;
          wr_d    = wr_en_i;
          state_d = REQ;
        end
      end
      REQ: begin
        if (dmi_req_ready_i) begin
          if (dmi_rsp_valid_i) begin
            rd_data_d = dmi_rsp_data_i;
            if (dmi_rsp_err_i) sticky_d = DMI_FAILED;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmi_rsp_valid_i) begin
          rd_data_d = dmi_rsp_data_i;
          if (dmi_rsp_err_i) sticky_d = DMI_FAILED;
          state_d = IDLE;
        end else if (timeout) begin
          sticky_d = DMI_FAILED;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (dmi_rsp_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (op_valid && (state_q != IDLE) && (sticky_q == DMI_OK) && (sticky_d == DMI_OK)) begin
      sticky_d = DMI_BUSY;
    end
    if (dmi_reset_i) sticky_d = DMI_OK;

    if (dmi_hard_reset_i) begin
      sticky_d  = DMI_OK;
      rd_data_d = rd_data_q;
      // A response landing with the hard reset is the one a drain would discard.
      if (state_q == REQ) begin
        state_d = IDLE;
      end else if (state_q == WAIT) begin
        state_d = dmi_rsp_valid_i ? IDLE : DRAIN;
      end
    end
  end

  always_comb begin
    dmi_req_valid_o = (state_q == REQ);
    if (sticky_q != DMI_OK) begin
      status = sticky_q;
    end else if (state_q != IDLE) begin
      status = DMI_BUSY;
    end else begin
      status = DMI_OK;
    end
  end

  assign rd_status_o    = status;
  assign dmi_stat_o     = status;
  assign rd_data_o      = rd_data_q;
  assign dmi_req_addr_o = addr_q;
  assign dmi_req_data_o = data_q;
  assign dmi_req_wr_o   = wr_q;

endmodule

// File: tb/tb_rvjtag_dmi_tracker.sv
// Directed self-checking bench for rvjtag_dmi_tracker.
module tb_rvjtag_dmi_tracker;

  logic        tck;
  logic        trst_n;
  logic        wr_en, rd_en;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        dmi_reset, dmi_hard_reset;
  logic [31:0] rd_data;
  logic [1:0]  rd_status, dmi_stat;
  logic        req_valid, req_ready, req_wr;
  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  rvjtag_dmi_tracker #(
    .AWIDTH        (7),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .tck_i           (tck),
    .trst_ni         (trst_n),
    .wr_en_i         (wr_en),
    .rd_en_i         (rd_en),
    .wr_addr_i       (wr_addr),
    .wr_data_i       (wr_data),
    .dmi_reset_i     (dmi_reset),
    .dmi_hard_reset_i(dmi_hard_reset),
    .rd_data_o       (rd_data),
    .rd_status_o     (rd_status),
    .dmi_stat_o      (dmi_stat),
    .dmi_req_valid_o (req_valid),
    .dmi_req_ready_i (req_ready),
    .dmi_req_addr_o  (req_addr),
    .dmi_req_data_o  (req_data),
    .dmi_req_wr_o    (req_wr),
    .dmi_rsp_valid_i (rsp_valid),
    .dmi_rsp_data_i  (rsp_data),
    .dmi_rsp_err_i   (rsp_err)
  );

  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  always @(posedge tck) begin
    if (req_valid && req_ready) hs_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic [1:0] exp);
    chk(tag, {30'd0, rd_status}, {30'd0, exp});
    chk({tag, "_stat"}, {30'd0, dmi_stat}, {30'd0, exp});
  endtask

  task automatic cyc();
    @(posedge tck);
    #1;
  endtask

  task automatic op(input logic w, input logic r, input logic [6:0] a, input logic [31:0] d);
    wr_en = w; rd_en = r; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic handshake();
    req_ready = 1'b1;
    cyc();
    req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input logic e);
    rsp_valid = 1'b1; rsp_data = d; rsp_err = e;
    cyc();
    rsp_valid = 1'b0; rsp_err = 1'b0;
  endtask

  initial begin
    trst_n = 1'b0;
    wr_en = 0; rd_en = 0; wr_addr = '0; wr_data = '0;
    dmi_reset = 0; dmi_hard_reset = 0;
    req_ready = 0; rsp_valid = 0; rsp_data = '0; rsp_err = 0;
    cyc(); cyc();
    chk("rst_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_wr", {31'd0, req_wr}, 32'd0);
    chk("rst_addr", {25'd0, req_addr}, 32'd0);
    chk("rst_data", req_data, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk_status("rst_status", 2'd0);
    trst_n = 1'b1;
    cyc();

    // 1: write with ready after 3 cycles
    op(1'b1, 1'b0, 7'h10, 32'hDEADBEEF);
    chk("t1_valid", {31'd0, req_valid}, 32'd1);
    chk("t1_addr", {25'd0, req_addr}, 32'h10);
    chk("t1_data", req_data, 32'hDEADBEEF);
    chk("t1_wr", {31'd0, req_wr}, 32'd1);
    chk_status("t1_busy_req", 2'd3);
    cyc(); cyc();
    chk("t1_valid_hold", {31'd0, req_valid}, 32'd1);
    chk("t1_data_hold", req_data, 32'hDEADBEEF);
    handshake();
    chk("t1_valid_drop", {31'd0, req_valid}, 32'd0);
    chk_status("t1_busy_wait", 2'd3);
    cyc();
    respond(32'hCAFE0001, 1'b0);
    chk_status("t1_done", 2'd0);
    chk("t1_rd_data", rd_data, 32'hCAFE0001);
    chk("t1_hs", hs_cnt, 32'd1);

    // reserved op encoding is ignored
    op(1'b1, 1'b1, 7'h7F, 32'hFFFFFFFF);
    chk("rsv_valid", {31'd0, req_valid}, 32'd0);
    chk_status("rsv_status", 2'd0);

    // 2: read
    op(1'b0, 1'b1, 7'h11, 32'h0);
    chk("t2_addr", {25'd0, req_addr}, 32'h11);
    chk("t2_wr", {31'd0, req_wr}, 32'd0);
    handshake();
    respond(32'h12345678, 1'b0);
    chk("t2_rd_data", rd_data, 32'h12345678);
    chk_status("t2_status", 2'd0);

    // 3: write dropped while waiting
    op(1'b1, 1'b0, 7'h12, 32'h00000001);
    handshake();
    op(1'b1, 1'b0, 7'h13, 32'h00000002);
    chk("t3_no_req", {31'd0, req_valid}, 32'd0);
    chk_status("t3_busy", 2'd3);
    respond(32'h00003333, 1'b0);
    chk_status("t3_sticky", 2'd3);
    chk("t3_hs", hs_cnt, 32'd3);
    chk("t3_addr_kept", {25'd0, req_addr}, 32'h12);
    dmi_reset = 1'b1; cyc(); dmi_reset = 1'b0;
    chk_status("t3_cleared", 2'd0);

    // 4: error response is sticky and wins over busy
    op(1'b0, 1'b1, 7'h13, 32'h0);
    handshake();
    respond(32'h0BADF00D, 1'b1);
    chk_status("t4_failed", 2'd2);
    chk("t4_rd_data", rd_data, 32'h0BADF00D);
    op(1'b0, 1'b1, 7'h14, 32'h0);
    op(1'b0, 1'b1, 7'h15, 32'h0);
    chk_status("t4_keep_failed", 2'd2);
    // handshake and response in the same cycle
    req_ready = 1'b1;
    respond(32'h00000055, 1'b0);
    req_ready = 1'b0;
    chk("t4_same_cyc_valid", {31'd0, req_valid}, 32'd0);
    chk("t4_same_cyc_data", rd_data, 32'h00000055);
    chk_status("t4_still_failed", 2'd2);
    dmi_reset = 1'b1; cyc(); dmi_reset = 1'b0;
    chk_status("t4_cleared", 2'd0);

    // dmi_reset in the same cycle as a busy op: clear wins
    op(1'b0, 1'b1, 7'h16, 32'h0);
    dmi_reset = 1'b1;
    op(1'b0, 1'b1, 7'h17, 32'h0);
    dmi_reset = 1'b0;
    chk_status("clr_wins_busy", 2'd3);
    handshake();
    respond(32'h00000066, 1'b0);
    chk_status("clr_wins_done", 2'd0);

    // response while idle is ignored
    respond(32'hFFFFFFFF, 1'b0);
    chk("idle_rsp_ign", rd_data, 32'h00000066);

    // 5: hard reset in WAIT, late response drained
    op(1'b0, 1'b1, 7'h18, 32'h0);
    handshake();
    dmi_hard_reset = 1'b1; cyc(); dmi_hard_reset = 1'b0;
    chk_status("t5_drain", 2'd3);
    chk("t5_drain_valid", {31'd0, req_valid}, 32'd0);
    op(1'b0, 1'b1, 7'h19, 32'h0);
    chk("t5_drain_no_req", {31'd0, req_valid}, 32'd0);
    respond(32'hAAAA5555, 1'b0);
    chk("t5_rd_unchanged", rd_data, 32'h00000066);
    dmi_reset = 1'b1; cyc(); dmi_reset = 1'b0;
    chk_status("t5_idle", 2'd0);
    // hard reset in REQ drops valid at once
    op(1'b0, 1'b1, 7'h1A, 32'h0);
    dmi_hard_reset = 1'b1; cyc(); dmi_hard_reset = 1'b0;
    chk("t5_req_abort", {31'd0, req_valid}, 32'd0);
    chk_status("t5_req_abort_st", 2'd0);
    op(1'b0, 1'b1, 7'h1B, 32'h0);
    chk("t5_next_addr", {25'd0, req_addr}, 32'h1B);
    handshake();
    respond(32'h600DD00D, 1'b0);
    chk("t5_next_data", rd_data, 32'h600DD00D);
    chk_status("t5_next_status", 2'd0);

    // trst mid-op returns to reset state immediately
    op(1'b1, 1'b0, 7'h1C, 32'h11112222);
    #2 trst_n = 1'b0;
    #1;
    chk("trst_valid", {31'd0, req_valid}, 32'd0);
    chk("trst_rd_data", rd_data, 32'd0);
    chk_status("trst_status", 2'd0);
    cyc();
    trst_n = 1'b1;
    cyc();

`ifdef RVJTAG_DMI_TIMEOUT_EN
    // 6: timeout after 16 WAIT cycles, next response discarded
    op(1'b0, 1'b1, 7'h1D, 32'h0);
    handshake();
    for (int i = 0; i < 15; i++) cyc();
    chk_status("t6_pre_timeout", 2'd3);
    cyc();
    chk_status("t6_timeout", 2'd2);
    respond(32'h12121212, 1'b0);
    chk("t6_discard", rd_data, 32'd0);
    chk_status("t6_sticky", 2'd2);
    dmi_reset = 1'b1; cyc(); dmi_reset = 1'b0;
    chk_status("t6_cleared", 2'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
